m8b_slot_arbiter: RTL
=====================

Name: m8b_slot_arbiter

Overview:
- Shares one 8-bit byte stream into the 8b->32b serial-to-parallel converter between two byte requesters.
- Time on the stream is divided into 4-beat word slots at clk_4f, aligned so the converter always receives whole 32-bit words.
- Whole slots are granted round-robin. Unclaimed slots go out as idle beats (valid low).
- Sits directly upstream of the converter's data_in/valid_in.

Parameters:
- DATA_W, 8, byte width of requester and output data.
- BEATS, 4, beats per slot (bytes per converter word); must be a power of 2.
- CNT_W, 16, width of the optional slot counters.

Ports:
- clk_4f input 1: byte-rate clock; the only clock.
- reset_L input 1: synchronous, active-low reset.
- req0 input 1: requester 0 holds at least BEATS bytes ready.
- data_in0 input DATA_W: requester 0 head byte, valid while ack0 is high.
- req1 input 1: requester 1 holds at least BEATS bytes ready.
- data_in1 input DATA_W: requester 1 head byte.
- ack0 output 1: pop strobe to requester 0; one byte is consumed per clk_4f edge while high.
- ack1 output 1: pop strobe to requester 1.
- data_out output DATA_W: byte to converter data_in.
- valid_out output 1: to converter valid_in.
- lane_out output 1: owner of the current output byte (0/1).
- slot_start output 1: high on the first output beat of each slot.
- slot_cnt0 output CNT_W: slots granted to requester 0 (SLOT_CNT_EN only).
- slot_cnt1 output CNT_W: slots granted to requester 1 (SLOT_CNT_EN only).

Behaviour:
- Reset, sampled on the clk_4f edge with reset_L=0:
  - phase=0, state=IDLE, last_grant=1 (requester 0 wins the first contention).
  - data_out=0, valid_out=0, lane_out=0, slot_start=0, slot counters=0.
  - ack0 and ack1 are forced 0 while reset_L=0.
- Phase counter: log2(BEATS) bits, increments every clk_4f and wraps BEATS-1 -> 0. A slot spans phase 0..BEATS-1.
- States: IDLE, GRANT0, GRANT1. Transitions happen only on the edge where phase==BEATS-1:
  - Only req0=1 -> GRANT0.
  - Only req1=1 -> GRANT1.
  - Both high -> grant the requester that is not last_grant, then update last_grant.
  - Neither high -> IDLE.
- The first slot after reset is always IDLE.
- req is sampled only at the slot boundary. A req change mid-slot has no effect, and a granted slot always runs all BEATS beats.
- Requester contract: req=1 guarantees BEATS bytes are available. The block does not check underflow.
- ack_i is combinational: (state==GRANTi) && reset_L. The requester presents its head on data_in_i and pops on the same edge.
- Output register, latency 1 cycle:
  - data_out <= granted data_in, or 0 when IDLE.
  - valid_out <= (state!=IDLE).
  - lane_out <= granted index (held when IDLE).
  - slot_start <= (phase==0).
- Output slots therefore occupy output phases 1..BEATS-1,0. The converter word alignment must match this.
- Back-to-back: a single continuous requester gets every slot with no gap beats.
- Reset mid-slot: the slot is aborted immediately. Bytes already popped are lost, with no partial-word recovery. Realignment restarts from phase 0.

Optional Feature:
- Macro: M8B_SLOT_ARBITER_SLOT_CNT_EN.
- Defined:
  - slot_cnt0/slot_cnt1 ports exist.
  - Each increments by 1 on the boundary edge that enters GRANT0/GRANT1, and wraps at 2^CNT_W.
  - Both are cleared by reset.
- Undefined: the ports and counters are absent. All other behaviour is identical.

Decomposition:
- Shared package m8b_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_GRANT0=2'd1, ST_GRANT1=2'd2;
  - default BEATS=4 and DATA_W=8, shared with the converter.
- One natural sub-module: m8b_rr_pick2. It is the combinational round-robin picker with inputs req0, req1, last_grant and outputs grant_valid, grant_idx.
- Phase counter, FSM and output register stay in the top.

Test Plan:
1. Reset, then req0=1 only, data_in0 stepping FF,FF,FF,FF,DD,DD,DD,DD:
   - slot 0 idle (valid_out=0);
   - next two slots output FF x4 then DD x4 with lane_out=0;
   - ack0 high 8 consecutive cycles.
2. req0=req1=1 continuously, data_in0=AA, data_in1=BB:
   - slots alternate AAx4 (lane 0), BBx4 (lane 1), AAx4...;
   - requester 0 is first.
3. Both idle for one slot, then req1 only with bytes 01,02,03,04:
   - 4 beats with valid_out=0 and data_out=00;
   - then 01,02,03,04 with lane_out=1 and slot_start high on 01.
4. req1 raised at phase 2 mid-IDLE and dropped at phase 1 of the next slot:
   - grant starts only at the boundary and completes all 4 beats;
   - exactly 4 acks.
5. reset_L dropped at phase 2 of a GRANT0 slot:
   - next cycle all outputs are 0 and ack0=0;
   - after release the first slot is idle and contention favours requester 0.
6. With M8B_SLOT_ARBITER_SLOT_CNT_EN defined, run scenario 2 for 6 slots:
   - slot_cnt0=3 and slot_cnt1=3;
   - counters read 0 after reset.

Source files
------------

// File: rtl/m8b_pkg.sv
// Shared definitions for the m8b byte-stream path: FSM state encoding and
// the default slot geometry also used by the 8b->32b converter.
package m8b_pkg;

  localparam int M8B_DATA_W = 8;
  localparam int M8B_BEATS  = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2
  } state_e;

endpackage

// File: rtl/m8b_rr_pick2.sv
// Two-way round-robin picker. When both requesters ask, the one that did not
// win last time is chosen; a lone requester always wins.
module m8b_rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_idx
);

  // Pick the winner for the next slot from the current requests
  always_comb begin
    grant_valid = req0 | req1;
    grant_idx   = 1'b0;
    if (req0 && req1) begin
      grant_idx = ~last_grant;
    end else if (req1) begin
      grant_idx = 1'b1;
    end
  end

endmodule

// File: rtl/m8b_slot_arbiter.sv
// Slot arbiter sharing one byte stream between two requesters. Time is cut
// into BEATS-beat word slots; whole slots are granted round-robin so the
// downstream converter only ever sees complete words. Unclaimed slots are
// sent as idle beats (valid_out low).
// Optional: define M8B_SLOT_ARBITER_SLOT_CNT_EN to add per-requester
// granted-slot counters on slot_cnt0/slot_cnt1.
module m8b_slot_arbiter
  import m8b_pkg::*;
#(
  parameter int DATA_W = M8B_DATA_W,
  parameter int BEATS  = M8B_BEATS,
  parameter int CNT_W  = 16
) (
  input  logic              clk_4f,
  input  logic              reset_L,
  input  logic              req0,
  input  logic [DATA_W-1:0] data_in0,
  input  logic              req1,
  input  logic [DATA_W-1:0] data_in1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              lane_out,
  output logic              slot_start
`ifdef M8B_SLOT_ARBITER_SLOT_CNT_EN
  ,
  output logic [CNT_W-1:0]  slot_cnt0,
  output logic [CNT_W-1:0]  slot_cnt1
`endif
);

  localparam int PH_W = $clog2(BEATS);

  logic [PH_W-1:0]   phase_q;
  logic [PH_W-1:0]   phase_d;
  state_e            state_q;
  logic              last_grant_q;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              lane_q;
  logic              slot_start_q;
  logic              boundary;
  logic              grant_valid;
  logic              grant_idx;

  assign phase_d  = phase_q + PH_W'(1);
  assign boundary = (phase_q == PH_W'(BEATS - 1));

  // Pops are tied to the current slot owner and suppressed while in reset so
  // no byte is consumed by an aborted slot on the reset edge.
  assign ack0 = (state_q == ST_GRANT0) && reset_L;
  assign ack1 = (state_q == ST_GRANT1) && reset_L;

  assign data_out   = data_q;
  assign valid_out  = valid_q;
  assign lane_out   = lane_q;
  assign slot_start = slot_start_q;

  m8b_rr_pick2 u_pick (
    .req0        (req0),
    .req1        (req1),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // Phase counter, slot FSM (changes only at the slot boundary) and the
  // one-cycle output register feeding the converter
  always_ff @(posedge clk_4f) begin
    if (!reset_L) begin
      phase_q      <= '0;
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      data_q       <= '0;
      valid_q      <= 1'b0;
      lane_q       <= 1'b0;
      slot_start_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      if (boundary) begin
        if (grant_valid) begin
          state_q      <= grant_idx ? ST_GRANT1 : ST_GRANT0;
          last_grant_q <= grant_idx;
        end else begin
          state_q <= ST_IDLE;
        end
      end
      case (state_q)
        ST_GRANT0: begin
          data_q  <= data_in0;
          valid_q <= 1'b1;
          lane_q  <= 1'b0;
        end
        ST_GRANT1: begin
          data_q  <= data_in1;
          valid_q <= 1'b1;
          lane_q  <= 1'b1;
        end
        default: begin
          data_q  <= '0;
          valid_q <= 1'b0;
        end
      endcase
      slot_start_q <= (phase_q == '0);
    end
  end

`ifdef M8B_SLOT_ARBITER_SLOT_CNT_EN
  logic [CNT_W-1:0] cnt0_q;
  logic [CNT_W-1:0] cnt1_q;

  assign slot_cnt0 = cnt0_q;
  assign slot_cnt1 = cnt1_q;

  // Count each slot at the boundary edge that hands it to a requester
  always_ff @(posedge clk_4f) begin
    if (!reset_L) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else if (boundary && grant_valid) begin
      if (grant_idx) begin
        cnt1_q <= cnt1_q + CNT_W'(1);
      end else begin
        cnt0_q <= cnt0_q + CNT_W'(1);
      end
    end
  end
`else
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule
